// File: rtl/pla_pkg.sv
// pla_pkg: shared types, sizes and cube match function for the sequential PLA evaluator
//   Sizes: N_IN inputs, N_OUT outputs, N_CUBES table entries, CPC cubes per EVAL cycle.
//   cube_t: one AND-plane/OR-plane table entry; state_e: evaluator FSM states.
package pla_pkg;
    localparam int N_IN    = 35;
    localparam int N_OUT   = 14;
    localparam int N_CUBES = 32;
    localparam int CPC     = 4;
    localparam int P       = N_CUBES / CPC;
    localparam int AW      = $clog2(N_CUBES);
    localparam int GW      = (P > 1) ? $clog2(P) : 1;

    typedef struct packed {
        logic             cvalid;
        logic [N_IN-1:0]  mask;
        logic [N_IN-1:0]  pol;
        logic [N_OUT-1:0] omask;
    } cube_t;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

    // Literals with mask=0 are don't-cares; present literals must equal pol.
    function automatic logic cube_match(input cube_t c, input logic [N_IN-1:0] v);
        return c.cvalid & (&(~c.mask | ~(v ^ c.pol)));
    endfunction
endpackage

// File: rtl/pla_cube_group.sv
// pla_cube_group: ORs the output masks of the matching cubes within one evaluation group
//   i_cubes : CPC table entries of the current group
//   i_data  : captured input vector
//   o_or    : OR of omask over the matching cubes
module pla_cube_group
    import pla_pkg::*;
(
    input  cube_t [CPC-1:0]  i_cubes,
    input  logic [N_IN-1:0]  i_data,
    output logic [N_OUT-1:0] o_or
);
    always_comb begin
        o_or = '0;
        for (int k = 0; k < CPC; k++)
            o_or = o_or | (cube_match(i_cubes[k], i_data) ? i_cubes[k].omask : '0);
    end
endmodule

// File: rtl/pla_seq_evaluator.sv
// pla_seq_evaluator: programmable sum-of-products table evaluated CPC cubes per clock
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    : input vector handshake (ready only in IDLE)
//   out_valid/out_ready/out_data : result handshake, held under backpressure
//   cfg_we/cfg_addr/cfg_cvalid/cfg_mask/cfg_pol/cfg_omask : cube table write (IDLE only)
//   cfg_inv_we/cfg_inv      : output inversion register write (IDLE only)
//   cfg_err                 : one-cycle pulse after a rejected config write
//   busy                    : engine not IDLE
module pla_seq_evaluator
    import pla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic             cfg_cvalid,
    input  logic [N_IN-1:0]  cfg_mask,
    input  logic [N_IN-1:0]  cfg_pol,
    input  logic [N_OUT-1:0] cfg_omask,
    input  logic             cfg_inv_we,
    input  logic [N_OUT-1:0] cfg_inv,
    output logic             cfg_err,
    output logic             busy
);
    if (N_CUBES % CPC != 0) begin : g_bad_cpc
        $error("N_CUBES must be a multiple of CUBES_PER_CYCLE");
    end

    cube_t            r_table [N_CUBES];
    state_e           r_state, w_next;
    logic [GW-1:0]    r_grp;
    logic [N_IN-1:0]  r_data;
    logic [N_OUT-1:0] r_acc, r_out, r_inv, w_or, w_acc_next;
    logic             r_err, w_accept, w_last, w_cfg_any, w_cfg_ok;
    cube_t [CPC-1:0]  w_cubes;

    always_comb begin
        for (int k = 0; k < CPC; k++)
            w_cubes[k] = r_table[AW'(int'(r_grp) * CPC + k)];
    end

    pla_cube_group u_group (
        .i_cubes (w_cubes),
        .i_data  (r_data),
        .o_or    (w_or)
    );

    assign w_accept   = in_valid && r_state == IDLE;
    assign w_last     = r_state == EVAL && int'(r_grp) == P - 1;
    assign w_acc_next = r_acc | w_or;
    assign w_cfg_any  = cfg_we | cfg_inv_we;
    // A combined table+inversion write is all-or-nothing: a bad address also drops the inversion write.
    assign w_cfg_ok   = w_cfg_any && r_state == IDLE && (!cfg_we || int'(cfg_addr) < N_CUBES);

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && in_valid)  ? EVAL :
                 w_last                          ? DONE :
                 (r_state == DONE && out_ready) ? IDLE : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grp   <= '0;
            r_data  <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_inv   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < N_CUBES; i++)
                r_table[i] <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_cfg_any & ~w_cfg_ok;
            if (w_cfg_ok && cfg_we)
                r_table[cfg_addr] <= '{cfg_cvalid, cfg_mask, cfg_pol, cfg_omask};
            if (w_cfg_ok && cfg_inv_we)
                r_inv <= cfg_inv;
            // Data/accumulator registers only load on accept or while evaluating.
            if (w_accept) begin
                r_data <= in_data;
                r_acc  <= '0;
                r_grp  <= '0;
            end else if (r_state == EVAL) begin
                r_acc <= w_acc_next;
                r_grp <= r_grp + 1'b1;
                if (w_last)
                    r_out <= w_acc_next ^ r_inv;
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign out_data  = r_out;
    assign cfg_err   = r_err;
endmodule

// File: tb/tb_pla_seq_evaluator.sv
// tb_pla_seq_evaluator: directed and randomized checks of pla_seq_evaluator against a table model
module tb_pla_seq_evaluator;
    import pla_pkg::*;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [N_IN-1:0]  in_data = '0, cfg_mask = '0, cfg_pol = '0;
    logic [N_OUT-1:0] out_data, cfg_omask = '0, cfg_inv = '0;
    logic             cfg_we = 1'b0, cfg_cvalid = 1'b0, cfg_inv_we = 1'b0, cfg_err, busy;
    logic [AW-1:0]    cfg_addr = '0;

    int checks = 0, errors = 0;

    logic             m_cv   [N_CUBES];
    logic [N_IN-1:0]  m_mask [N_CUBES];
    logic [N_IN-1:0]  m_pol  [N_CUBES];
    logic [N_OUT-1:0] m_om   [N_CUBES];
    logic [N_OUT-1:0] m_inv;

    pla_seq_evaluator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cvalid(cfg_cvalid),
        .cfg_mask(cfg_mask), .cfg_pol(cfg_pol), .cfg_omask(cfg_omask),
        .cfg_inv_we(cfg_inv_we), .cfg_inv(cfg_inv),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] v);
        logic [N_OUT-1:0] r = '0;
        for (int c = 0; c < N_CUBES; c++)
            if (m_cv[c] && ((v & m_mask[c]) == (m_pol[c] & m_mask[c])))
                r |= m_om[c];
        return r ^ m_inv;
    endfunction

    function automatic logic [N_IN-1:0] rnd_in();
        logic [63:0] t = {$urandom, $urandom};
        return N_IN'(t);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CUBES; c++) begin
            m_cv[c] = 1'b0; m_mask[c] = '0; m_pol[c] = '0; m_om[c] = '0;
        end
        m_inv = '0;
    endtask

    task automatic set_cube(input int a, input logic cv, input logic [N_IN-1:0] mk,
                            input logic [N_IN-1:0] pl, input logic [N_OUT-1:0] om);
        cfg_addr = AW'(a); cfg_cvalid = cv; cfg_mask = mk; cfg_pol = pl; cfg_omask = om;
    endtask

    task automatic cfg_write(input int a, input logic cv, input logic [N_IN-1:0] mk,
                             input logic [N_IN-1:0] pl, input logic [N_OUT-1:0] om);
        set_cube(a, cv, mk, pl, om);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_cv[a] = cv; m_mask[a] = mk; m_pol[a] = pl; m_om[a] = om;
        chk("cfg_err_idle", cfg_err, 0);
    endtask

    task automatic inv_write(input logic [N_OUT-1:0] v);
        cfg_inv = v; cfg_inv_we = 1'b1;
        @(posedge clk); #1;
        cfg_inv_we = 1'b0;
        m_inv = v;
    endtask

    task automatic start(input logic [N_IN-1:0] v);
        in_valid = 1'b1; in_data = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    // lat = edges still expected until out_valid; hold = cycles of backpressure with a stray in_valid.
    task automatic finish(input string tag, input logic [N_IN-1:0] v, input int lat, input int hold);
        int n = 0;
        logic [N_OUT-1:0] exp = model(v);
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_data"}, out_data, exp);
        in_valid = hold > 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, out_data, exp);
    endtask

    task automatic run(input string tag, input logic [N_IN-1:0] v);
        chk({tag, "_in_ready"}, in_ready, 1);
        start(v);
        finish(tag, v, P, 0);
    endtask

    initial begin
        logic [N_IN-1:0] v;
        model_clear();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);

        run("empty", '0);

        cfg_write(0, 1'b1, N_IN'(4'hF), N_IN'(4'hF), N_OUT'(1));
        run("and4_hit", N_IN'(4'hF));
        run("and4_miss", N_IN'(4'h7));

        cfg_write(0, 1'b0, '0, '0, '0);
        inv_write(N_OUT'(14'h0020));
        run("inv_only", rnd_in());
        cfg_write(1, 1'b1, N_IN'(1) << 5, N_IN'(1) << 5, N_OUT'(14'h0020));
        run("nv5_one", N_IN'(1) << 5);
        run("nv5_zero", ~(N_IN'(1) << 5));

        v = rnd_in();
        start(v);
        finish("backpressure", v, P, 10);

        v = rnd_in();
        start(v);
        @(posedge clk); #1;
        set_cube(2, 1'b1, '0, '0, '1);
        cfg_we = 1'b1; cfg_inv = '1; cfg_inv_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_inv_we = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        @(posedge clk); #1;
        chk("cfg_err_clear", cfg_err, 0);
        finish("eval_write", v, P - 3, 0);
        run("eval_write_again", v);

        v = rnd_in();
        set_cube(3, 1'b1, '0, '0, N_OUT'(14'h0100));
        cfg_we = 1'b1; in_valid = 1'b1; in_data = v;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        m_cv[3] = 1'b1; m_mask[3] = '0; m_pol[3] = '0; m_om[3] = N_OUT'(14'h0100);
        chk("same_edge_cfg_err", cfg_err, 0);
        finish("same_edge", v, P, 0);

        cfg_write(4, 1'b1, '0, '0, '1);
        v = rnd_in();
        start(v);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
        run("after_abort", v);
        chk("after_abort_zero", out_data, 0);

        for (int it = 0; it < 25; it++) begin
            int nw = $urandom_range(3, 1);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(N_CUBES - 1), ($urandom % 4) != 0,
                          rnd_in() & rnd_in() & rnd_in(), rnd_in(), N_OUT'($urandom));
            if ($urandom % 4 == 0)
                inv_write(N_OUT'($urandom));
            v = rnd_in();
            if ($urandom % 2 == 1) begin
                int c = $urandom_range(N_CUBES - 1);
                v = (v & ~m_mask[c]) | (m_pol[c] & m_mask[c]);
            end
            run("random", v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
